muldiv_sequencer: RTL

- Multi-cycle unsigned MULTU/DIVU unit for the MIPS core.
- Owns no adder. Each cycle it drives the shared 32-bit AdderAndSubtractor datapath through its A/B/Cin inputs and consumes its 32-bit Out.
- Produces HI/LO results with a start/busy/done handshake.
- Sits beside the ALU and feeds the HI/LO register path.

---
 rtl/muldiv_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned MULTU/DIVU sequencer driving a shared external adder
// Ports:
//   i_clk, i_reset      rising-edge clock, synchronous active-high reset
//   i_start, i_op       request (sampled in IDLE only), 0 = MULTU, 1 = DIVU
//   i_src_a, i_src_b    multiplicand/dividend, multiplier/divisor
//   o_busy, o_done      high while iterating, one-cycle result-valid pulse
//   o_div_by_zero       valid with o_done for DIVU by zero
//   o_hi, o_lo          MULTU product high/low, DIVU remainder/quotient
//   o_adder_a/b/cin     operands to the shared adder (cin = 1 subtracts)
//   i_adder_sum         combinational sum returned by the shared adder
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_adder_a,
    output logic [WIDTH-1:0] o_adder_b,
    output logic             o_adder_cin,
    input  logic [WIDTH-1:0] i_adder_sum
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
    logic r_op, r_dbz;
    logic w_run, w_zero, w_b, w_co;
    assign w_run = (r_state == RUN);
    assign w_zero = (i_src_b == '0);
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? ((i_op && w_zero) ? DONE : RUN) : IDLE;
            RUN:     w_next = (r_cnt == LAST) ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end
    assign o_busy = w_run;
    assign o_done = (r_state == DONE);
    assign o_div_by_zero = o_done & r_dbz;
    assign o_hi = r_hi;
    assign o_lo = r_lo;
    // DIVU presents the partial remainder shifted left by one, pulling in the next dividend bit
    assign o_adder_a = !w_run ? '0 : r_op ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : r_hi;
    assign o_adder_b = w_run ? r_opnd : '0;
    assign o_adder_cin = w_run & r_op;
    // The adder has no carry-out; rebuild it from the MSBs. For subtract the adder
    // sees ~b, so the same add formula applies to the inverted B bit (co = no borrow).
    assign w_b = r_op ? ~o_adder_b[WIDTH-1] : o_adder_b[WIDTH-1];
    assign w_co = (o_adder_a[WIDTH-1] & w_b) | ((o_adder_a[WIDTH-1] | w_b) & ~i_adder_sum[WIDTH-1]);
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_hi <= '0;
            r_lo <= '0;
            r_opnd <= '0;
            r_op <= 1'b0;
            r_dbz <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_cnt <= '0;
            r_op <= i_op;
            r_opnd <= i_op ? i_src_b : i_src_a;
            r_dbz <= i_op & w_zero;
            r_hi <= (i_op && w_zero) ? i_src_a : '0;
            r_lo <= i_op ? (w_zero ? '1 : i_src_a) : i_src_b;
        end else if (w_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_op) begin
                {r_hi, r_lo} <= r_lo[0] ? {w_co, i_adder_sum, r_lo[WIDTH-1:1]}
                                        : {1'b0, r_hi, r_lo[WIDTH-1:1]};
            end else if (r_hi[WIDTH-1] | w_co) begin
                // The bit shifted out of hi means the partial remainder already exceeds the divisor
                r_hi <= i_adder_sum;
                r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                r_hi <= o_adder_a;
                r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule
